// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_pkg
// Description : Shared types, constants and the byte-merge helper for the
//               single-clock 1W/1R byte-writable SRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_pkg;

  // Array controller state: zeroing sweep after reset, then normal operation.
  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } sram_state_e;

  // Supported read pipeline depths.
  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;

  // Select one byte lane: the new byte where its mask bit is set, else the old one.
  // The write path and the same-address bypass both use it, so they always agree.
  function automatic logic [7:0] byte_merge(
    input logic [7:0] old_byte,
    input logic [7:0] new_byte,
    input logic       mask
  );
    return mask ? new_byte : old_byte;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_init_fsm.sv
`default_nettype none
// ============================================================================
// Module      : sram_init_fsm
// Description : Post-reset zeroing sweep controller. Walks every address once
//               in INIT, then parks in RUN and raises ready.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_init_fsm
  import sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  rstb,
  output logic                  init_we,
  output logic [ADDR_WIDTH-1:0] init_addr,
  output logic                  ready
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  sram_state_e           state;
  sram_state_e           state_nxt;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [ADDR_WIDTH-1:0] init_cnt_nxt;
  logic                  ready_nxt;

  // State register; reset restarts the sweep from address zero.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= INIT;
      init_cnt <= '0;
      ready    <= 1'b0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
      ready    <= ready_nxt;
    end
  end

  // Next-state logic: leave INIT on the same edge that zeroes the last word.
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    ready_nxt    = ready;
    case (state)
      INIT: begin
        init_cnt_nxt = init_cnt + CNT_ONE;
        if (init_cnt == LAST_ADDR) begin
          state_nxt    = RUN;
          ready_nxt    = 1'b1;
          init_cnt_nxt = '0;
        end
      end
      RUN: begin
        state_nxt = RUN;
      end
      default: begin
        state_nxt = INIT;
      end
    endcase
  end

  assign init_we   = (state == INIT);
  assign init_addr = init_cnt;

endmodule
`default_nettype wire

// File: rtl/sram_1r1w_bw_bypass.sv
`default_nettype none
// ============================================================================
// Module      : sram_1r1w_bw_bypass
// Description : Single-clock 1W/1R SRAM model with per-byte write mask,
//               1- or 2-stage read pipeline, selectable same-address bypass
//               and a hardware zeroing sweep after reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_1r1w_bw_bypass
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 9,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS       = 1
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      csb0,
  input  logic [DATA_WIDTH/8-1:0]   wmask0,
  input  logic [ADDR_WIDTH-1:0]     addr0,
  input  logic [DATA_WIDTH-1:0]     din0,
  input  logic                      csb1,
  input  logic [ADDR_WIDTH-1:0]     addr1,
  output logic [DATA_WIDTH-1:0]     dout1,
  output logic                      dout1_valid,
  output logic                      collision1,
  output logic                      ready
);

  localparam int RAM_DEPTH   = 1 << ADDR_WIDTH;
  localparam int WMASK_WIDTH = DATA_WIDTH / 8;

  if (DATA_WIDTH % 8 != 0) begin : g_err_width
    $error("sram_1r1w_bw_bypass: DATA_WIDTH (%0d) must be a multiple of 8", DATA_WIDTH);
  end
  if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_err_latency
    $error("sram_1r1w_bw_bypass: READ_LATENCY (%0d) must be 1 or 2", READ_LATENCY);
  end

  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  wr_en;
  logic                  rd_en;
  logic                  hit;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_old;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  s1_valid;
  logic                  s1_coll;
  logic [DATA_WIDTH-1:0] s1_data;

  sram_init_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_init_fsm (
    .clk       (clk),
    .rstb      (rstb),
    .init_we   (init_we),
    .init_addr (init_addr),
    .ready     (ready)
  );

  // User ports are only honoured once the sweep has finished.
  assign wr_en  = ready & ~csb0;
  assign rd_en  = ready & ~csb1;
  assign hit    = wr_en & rd_en & (addr0 == addr1);
  assign wr_old = mem[addr0];
  assign rd_old = mem[addr1];

  for (genvar i = 0; i < WMASK_WIDTH; i++) begin : g_lane
    assign wr_merged[8*i +: 8] = byte_merge(wr_old[8*i +: 8], din0[8*i +: 8], wmask0[i]);
  end

  // On a same-address hit wr_merged is built from the word being read, so it
  // is exactly the post-write value the bypass policy wants to return.
  assign rd_word = ((BYPASS != 0) && hit) ? wr_merged : rd_old;

  // Array update: the sweep owns the array in INIT, user writes land only in RUN.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= '0;
    end else if (wr_en) begin
      mem[addr0] <= wr_merged;
    end
  end

  // First read stage: data holds between reads so dout1 never returns to X.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1_valid <= 1'b0;
      s1_coll  <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_en;
      s1_coll  <= hit;
      if (rd_en) begin
        s1_data <= rd_word;
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s2_valid;
    logic                  s2_coll;
    logic [DATA_WIDTH-1:0] s2_data;

    // Second read stage: one extra cycle, same hold behaviour as stage one.
    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        s2_valid <= 1'b0;
        s2_coll  <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        s2_coll  <= s1_coll;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign dout1       = s2_data;
    assign dout1_valid = s2_valid;
    assign collision1  = s2_coll;
  end else begin : g_lat1
    assign dout1       = s1_data;
    assign dout1_valid = s1_valid;
    assign collision1  = s1_coll;
  end

endmodule
`default_nettype wire

// File: doc/sram_1r1w_bw_bypass.md
Name: sram_1r1w_bw_bypass

Overview:
Parametrised, synthesizable single-clock 1W/1R SRAM macro model and the successor of the dual-clock 0rw1r1w models. It adds per-byte write masking, a configurable read pipeline depth and a selectable same-address bypass policy. After reset, a hardware init sweep zeroes every word. It sits beside the OpenRAM-generated macros as a drop-in for single-clock-domain users.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 9, address width; RAM_DEPTH = 1 << ADDR_WIDTH (localparam).
READ_LATENCY, 1, read pipeline depth; legal values are 1 and 2.
BYPASS, 1, same-address read/write policy: 1 returns new (merged) data, 0 returns old data.
WMASK_WIDTH, DATA_WIDTH/8, localparam: one mask bit per byte.

Ports:
clk  input  1  single clock; all state changes on posedge.
rstb  input  1  asynchronous reset, active-low.
csb0  input  1  write-port select, active-low.
wmask0  input  WMASK_WIDTH  per-byte write enable; bit i covers din0[8i+7:8i].
addr0  input  ADDR_WIDTH  write address.
din0  input  DATA_WIDTH  write data.
csb1  input  1  read-port select, active-low.
addr1  input  ADDR_WIDTH  read address.
dout1  output  DATA_WIDTH  read data, registered.
dout1_valid  output  1  high for exactly one cycle per accepted read.
collision1  output  1  high together with dout1_valid when that read hit the same-edge write address.
ready  output  1  high once the init sweep is complete; accesses are accepted only while ready=1.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rstb).
- Reset (rstb=0, asynchronous): state=INIT, init_cnt=0, ready=0, dout1=0, dout1_valid=0, collision1=0, read pipeline valid bits cleared.
- FSM has two states, INIT and RUN.
- INIT behaviour:
  - Each posedge writes all-zero to mem[init_cnt], then increments init_cnt.
  - At init_cnt==RAM_DEPTH-1, that final word is written and the next state is RUN.
  - ready rises at the RAM_DEPTH-th posedge after rstb deasserts.
  - csb0/csb1 are ignored: writes are dropped and no read is issued.
- RUN behaviour:
  - RUN is terminal until the next reset.
  - Write (csb0=0 at posedge): for each i with wmask0[i]=1, the byte is written into mem[addr0]. wmask0=0 is a legal no-op.
  - Read (csb1=0 at posedge N): the pipeline latches addr1.
    - READ_LATENCY=1: dout1/dout1_valid are updated by edge N+1, i.e. visible in the cycle after N.
    - READ_LATENCY=2: one further register stage adds a cycle.
  - Back-to-back reads each cycle are supported at full throughput.
- dout1 hold rule: dout1 holds its last value when no read completes; it never goes X. dout1_valid=0 in those cycles.
- Collision (RUN, csb0=0, csb1=0 and addr0==addr1 at the same edge):
  - BYPASS=1: dout1 = bytes from din0 where wmask0=1, bytes from old mem elsewhere.
  - BYPASS=0: dout1 = old mem contents.
  - In both cases the memory takes the write, and collision1=1 is aligned with that read's dout1_valid.
- Read-after-write to the same address on a later edge always returns the new data.
- Reset mid-operation: in-flight reads are dropped (valid cleared), the FSM re-enters INIT and memory is re-zeroed. Partial writes are never observable after ready rises.
- Elaboration-time $error if DATA_WIDTH%8!=0 or READ_LATENCY is not in {1,2}.

Decomposition:
- Shared package sram_pkg contains:
  - state enum sram_state_e {INIT, RUN};
  - a byte-merge function (old, new, mask) used by both the write path and bypass;
  - the legal-latency constants.
- One natural sub-module, sram_init_fsm: owns state, init_cnt and ready, and outputs the init write enable and address. The top-level muxes the init and user write paths into the array.

Test Plan:
(Run with DATA_WIDTH=32, ADDR_WIDTH=4.)
1. Release rstb, keep csb0=csb1=0 throughout -> ready=0 for 16 cycles and then 1; reads during INIT give no dout1_valid. The first RUN read of each of addr 0..15 returns 0x00000000.
2. Write addr 3 with din0=0xAABBCCDD, wmask0=4'b1111; next cycle write addr 3 with din0=0x11223344, wmask0=4'b0101; then read addr 3 -> dout1=0xAA22CC44 with dout1_valid=1 after READ_LATENCY cycles.
3. Addr 5 holds 0x00000000; on the same edge write 0xDEADBEEF with mask 4'b1100 and read addr 5.
   - BYPASS=1 -> dout1=0xDEAD0000, collision1=1.
   - BYPASS=0 -> dout1=0x00000000, collision1=1.
   - In both builds, a subsequent read gives 0xDEAD0000, collision1=0.
4. READ_LATENCY=2: read addresses 1, 2, 3 on consecutive edges -> three consecutive dout1_valid pulses starting 2 cycles after the first request, with data in order; dout1 holds the last value afterwards with dout1_valid=0.
5. Assert rstb=0 with two reads in flight -> dout1_valid drops immediately; after release ready=0 for 16 cycles, and all addresses then read back 0.
6. Same-edge write and read of different addresses (write 0x12345678 to addr 7, read addr 8 holding 0x0) -> dout1=0x0, collision1=0; a read of addr 7 on the next edge returns 0x12345678.
